// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command sequencer: opcodes, FSM states and
// the width of one queued command record.
package gpu_pkg;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STROBE = 2'd2,
        ST_WAIT   = 2'd3
    } seq_state_t;

    // op + address + address_x/address_y/image_width + clear_color
    localparam int CMD_FIXED_W = 1 + 32 + 3 * 16 + 16;

    function automatic int cmd_rec_w(input int ww, input int hw);
        return CMD_FIXED_W + 2 * ww + 2 * hw;
    endfunction

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO holding queued GPU commands; the head entry is always
// visible on rd_data, and a write never shows up in the same cycle.
module gpu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance depends only on the current count, never on a same-cycle pop.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

endmodule

// File: rtl/gpu_cmd_sequencer.sv
// Queues draw/clear commands and issues them one at a time to the GPU as a
// single-cycle strobe, holding the parameters stable until the GPU is done.
module gpu_cmd_sequencer
    import gpu_pkg::*;
#(
    parameter int FB_WIDTH  = 400,
    parameter int FB_HEIGHT = 240,
    parameter int DEPTH     = 8,
    localparam int WW = $clog2(FB_WIDTH) + 2,
    localparam int HW = $clog2(FB_HEIGHT) + 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [31:0]   cmd_address,
    input  logic [15:0]   cmd_address_x,
    input  logic [15:0]   cmd_address_y,
    input  logic [15:0]   cmd_image_width,
    input  logic [WW-1:0] cmd_width,
    input  logic [WW-1:0] cmd_x,
    input  logic [HW-1:0] cmd_height,
    input  logic [HW-1:0] cmd_y,
    input  logic [15:0]   cmd_clear_color,
    output logic [31:0]   gpu_address,
    output logic [15:0]   gpu_address_x,
    output logic [15:0]   gpu_address_y,
    output logic [15:0]   gpu_image_width,
    output logic [WW-1:0] gpu_width,
    output logic [HW-1:0] gpu_height,
    output logic [WW-1:0] gpu_x,
    output logic [HW-1:0] gpu_y,
    output logic [15:0]   gpu_clear_color,
    output logic          gpu_draw,
    output logic          gpu_clear,
    input  logic          gpu_busy,
    output logic [CW-1:0] queue_count,
    output logic          idle,
    output logic [15:0]   done_count
);

    typedef struct packed {
        logic          op;
        logic [31:0]   address;
        logic [15:0]   address_x;
        logic [15:0]   address_y;
        logic [15:0]   image_width;
        logic [WW-1:0] width;
        logic [WW-1:0] x;
        logic [HW-1:0] height;
        logic [HW-1:0] y;
        logic [15:0]   clear_color;
    } cmd_t;

    localparam int REC_W = cmd_rec_w(WW, HW);

    seq_state_t state;
    cmd_t       push_rec, head, hold, hold_nxt;
    logic       full, empty, pop, degenerate;

    assign push_rec = '{op: cmd_op, address: cmd_address, address_x: cmd_address_x,
                        address_y: cmd_address_y, image_width: cmd_image_width,
                        width: cmd_width, x: cmd_x, height: cmd_height, y: cmd_y,
                        clear_color: cmd_clear_color};

    gpu_cmd_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cmd_valid),
        .wr_data (push_rec),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (queue_count)
    );

    assign cmd_ready  = !full;
    assign idle       = empty && (state == ST_IDLE);
    assign pop        = (state == ST_IDLE) && !empty && !gpu_busy;
    assign degenerate = (hold.op == OP_DRAW) && (hold.width == '0 || hold.height == '0);

    // A clear only carries a colour; a draw leaves the last clear colour alone.
    always_comb begin
        hold_nxt = hold;
        if (head.op == OP_CLEAR) begin
            hold_nxt.op          = OP_CLEAR;
            hold_nxt.clear_color = head.clear_color;
        end else begin
            hold_nxt             = head;
            hold_nxt.clear_color = hold.clear_color;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold       <= '0;
            gpu_draw   <= 1'b0;
            gpu_clear  <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        hold  <= hold_nxt;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (degenerate) begin
                        done_count <= done_count + 16'd1;
                        state      <= ST_IDLE;
                    end else begin
                        gpu_draw  <= (hold.op == OP_DRAW);
                        gpu_clear <= (hold.op == OP_CLEAR);
                        state     <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    gpu_draw  <= 1'b0;
                    gpu_clear <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!gpu_busy) begin
                        done_count <= done_count + 16'd1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign gpu_address     = hold.address;
    assign gpu_address_x   = hold.address_x;
    assign gpu_address_y   = hold.address_y;
    assign gpu_image_width = hold.image_width;
    assign gpu_width       = hold.width;
    assign gpu_height      = hold.height;
    assign gpu_x           = hold.x;
    assign gpu_y           = hold.y;
    assign gpu_clear_color = hold.clear_color;

endmodule
